// File: rtl/varint_in_arbiter.sv
// varint_in_arbiter: round-robin arbiter sharing the varint encoder input FIFO between producer lanes.
// A grant is held for a whole message; one {lane, word count} descriptor is pushed per message.
//
// state | meaning
// IDLE  | no grant; scan lanes from rr_ptr+1 (with wrap) for a non-empty FIFO
// XFER  | granted lane streams words until its last word or a forced close at 255 words
// CLOSE | granted lane becomes rr_ptr, grant dropped
module varint_in_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_empty,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_pop,
  input  logic                      enc_fifo_full,
  output logic                      enc_fifo_push,
  output logic [DATA_W-1:0]         enc_fifo_data,
  input  logic                      enc_index_full,
  output logic                      enc_index_push,
  output logic [ID_W+CNT_W-1:0]     enc_index_data,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      len_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  // Word count at which the current word is forced to close the message.
  localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'((1 << CNT_W) - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  RR_RESET  = ID_W'(NUM_REQ - 1);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic             len_err_q, len_err_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic             head_empty;
  logic             head_last;
  logic [DATA_W-1:0] head_data;
  logic             closing;
  logic             xfer;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found && !req_empty[rr_ptr_q + ID_W'(k)]) begin
        pick_found = 1'b1;
        pick_id    = rr_ptr_q + ID_W'(k);
      end
    end
  end

  always_comb begin
    head_empty = req_empty[grant_id_q];
    head_last  = req_last[grant_id_q];
    head_data  = req_data[grant_id_q*DATA_W +: DATA_W];
    closing    = head_last || (word_cnt_q == CNT_FORCE);
    xfer       = !reset && (state_q == XFER) && !head_empty && !enc_fifo_full &&
                 (!closing || !enc_index_full);
  end

  always_comb begin
    req_pop = '0;
    if (xfer) begin
      req_pop[grant_id_q] = 1'b1;
    end
    enc_fifo_push  = xfer;
    enc_fifo_data  = head_data;
    enc_index_push = xfer && closing;
    enc_index_data = '0;
    if (enc_index_push) begin
      enc_index_data = {grant_id_q, word_cnt_q + CNT_ONE};
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    len_err_d     = len_err_q;
    word_cnt_d    = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          word_cnt_d    = '0;
          state_d       = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + CNT_ONE;
          if (closing) begin
            state_d = CLOSE;
            if (!head_last) begin
              len_err_d = 1'b1;
            end
          end
        end
      end
      CLOSE: begin
        rr_ptr_d      = grant_id_q;
        grant_valid_d = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= RR_RESET;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      word_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      len_err_q     <= len_err_d;
      word_cnt_q    <= word_cnt_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_varint_in_arbiter.sv
// tb_varint_in_arbiter: lane FIFOs modelled as queues; a negedge monitor checks every DUT cycle
// against per-lane expected word/descriptor queues and a round-robin grant model.
module tb_varint_in_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_empty = '1;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_pop;
  logic            enc_fifo_full = 1'b0;
  logic            enc_fifo_push;
  logic [DW-1:0]   enc_fifo_data;
  logic            enc_index_full = 1'b0;
  logic            enc_index_push;
  logic [IW+CW-1:0] enc_index_data;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;
  logic            len_err;

  varint_in_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_empty(req_empty), .req_data(req_data), .req_last(req_last), .req_pop(req_pop),
    .enc_fifo_full(enc_fifo_full), .enc_fifo_push(enc_fifo_push), .enc_fifo_data(enc_fifo_data),
    .enc_index_full(enc_index_full), .enc_index_push(enc_index_push), .enc_index_data(enc_index_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side: lane contents, expected words and expected descriptor counts per lane.
  logic [DW:0]   lane_q [N][$];
  logic [DW-1:0] exp_word [N][$];
  int            exp_idx [N][$];
  int            stim_cnt [N];
  int            hide [N];
  int            force_full = 0;
  int            force_idx = 0;
  bit            rand_mode = 0;

  // Monitor-side model state.
  int           model_rr = N-1;
  int           cur_g = 0;
  int           msg_cnt = 0;
  int           close_age = 0;
  bit           in_msg = 0;
  bit           prev_gv = 0;
  bit           post_reset = 0;
  bit           exp_len_err = 0;
  bit           len_err_pend = 0;
  logic [N-1:0] prev_empty = '1;
  logic [N-1:0] pop_seen = '0;

  function automatic void add_word(input int l, input logic [DW-1:0] d, input bit last);
    lane_q[l].push_back({last, d});
    exp_word[l].push_back(d);
    stim_cnt[l]++;
    if (last || stim_cnt[l] == 255) begin
      exp_idx[l].push_back(stim_cnt[l]);
      stim_cnt[l] = 0;
    end
  endfunction

  function automatic void add_msg(input int l, input int len, input bit with_last);
    for (int i = 0; i < len; i++) add_word(l, $urandom, with_last && (i == len-1));
  endfunction

  function automatic void drive();
    logic [DW:0] h;
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0 && hide[i] == 0) begin
        h = lane_q[i][0];
        req_empty[i] = 1'b0;
        req_data[i*DW +: DW] = h[DW-1:0];
        req_last[i] = h[DW];
      end else begin
        req_empty[i] = 1'b1;
        req_data[i*DW +: DW] = '0;
        req_last[i] = 1'b0;
      end
    end
    enc_fifo_full  = (force_full > 0) || (rand_mode && $urandom_range(0, 3) == 0);
    enc_index_full = (force_idx > 0)  || (rand_mode && $urandom_range(0, 3) == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pop_seen[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      if (hide[i] > 0) hide[i]--;
    end
    if (force_full > 0) force_full--;
    if (force_idx > 0) force_idx--;
    drive();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int quiet = 0;
    bit busy;
    for (int c = 0; c < budget && quiet < 3; c++) begin
      step();
      busy = grant_valid;
      for (int i = 0; i < N; i++) if (lane_q[i].size() > 0) busy = 1;
      quiet = busy ? 0 : quiet + 1;
    end
    chk({"drain_", name}, 64'(quiet >= 3), 64'(1));
  endtask

  task automatic wait_mid(input int l, input int remain, input string name);
    bit hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      step();
      hit = grant_valid && (grant_id == IW'(l)) && (lane_q[l].size() <= remain);
    end
    chk({"reach_", name}, 64'(hit), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    step();
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete(); exp_word[i].delete(); exp_idx[i].delete();
      stim_cnt[i] = 0; hide[i] = 0;
    end
    force_full = 0; force_idx = 0;
    drive();
    step();
    reset = 1'b0;
    drive();
  endtask

  function automatic int rr_pick(input logic [N-1:0] empty, input int rr);
    for (int k = 1; k <= N; k++) if (!empty[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    logic [DW-1:0] hd;
    bit hl, he, closing, exp_xfer;
    int e;
    if (reset) begin
      chk("reset_fifo_push", 64'(enc_fifo_push), 64'(0));
      chk("reset_index_push", 64'(enc_index_push), 64'(0));
      chk("reset_req_pop", 64'(req_pop), 64'(0));
      model_rr = N-1; in_msg = 0; close_age = 0; exp_len_err = 0; len_err_pend = 0;
      prev_gv = 0; prev_empty = '1; post_reset = 1; pop_seen = '0;
    end else begin
      if (post_reset) begin
        chk("post_reset_grant_id", 64'(grant_id), 64'(0));
        post_reset = 0;
      end
      if (len_err_pend) exp_len_err = 1;
      len_err_pend = 0;
      chk("len_err", 64'(len_err), 64'(exp_len_err));
      if (!in_msg) begin
        if (close_age == 1) begin
          chk("close_grant_held", 64'(grant_valid), 64'(1));
          close_age = 2;
        end else if (close_age == 2) begin
          chk("close_grant_drop", 64'(grant_valid), 64'(0));
          close_age = 0;
        end else if (!prev_gv) begin
          e = rr_pick(prev_empty, model_rr);
          chk("grant_valid_rise", 64'(grant_valid), 64'(e >= 0));
          if (e >= 0) begin
            chk("grant_id", 64'(grant_id), 64'(e));
            in_msg = 1; cur_g = e; msg_cnt = 0;
          end
        end
      end
      if (in_msg) begin
        he = req_empty[cur_g];
        hl = req_last[cur_g];
        hd = req_data[cur_g*DW +: DW];
        closing  = hl || (msg_cnt == 254);
        exp_xfer = !he && !enc_fifo_full && (!closing || !enc_index_full);
        chk("grant_hold", 64'({grant_valid, grant_id}), 64'({1'b1, IW'(cur_g)}));
        chk("fifo_push", 64'(enc_fifo_push), 64'(exp_xfer));
        chk("req_pop", 64'(req_pop), exp_xfer ? 64'(N'(1) << cur_g) : 64'(0));
        chk("index_push", 64'(enc_index_push), 64'(exp_xfer && closing));
        if (exp_xfer && enc_fifo_push) begin
          chk("word_expected", 64'(exp_word[cur_g].size() > 0), 64'(1));
          if (exp_word[cur_g].size() > 0) chk("fifo_data", 64'(enc_fifo_data), 64'(exp_word[cur_g].pop_front()));
          chk("fifo_data_is_head", 64'(enc_fifo_data), 64'(hd));
          msg_cnt++;
          if (closing && enc_index_push) begin
            chk("index_data", 64'(enc_index_data), 64'({IW'(cur_g), CW'(msg_cnt)}));
            chk("index_expected", 64'(exp_idx[cur_g].size() > 0), 64'(1));
            if (exp_idx[cur_g].size() > 0) chk("index_count", 64'(msg_cnt), 64'(exp_idx[cur_g].pop_front()));
            if (!hl) len_err_pend = 1;
            model_rr = cur_g; in_msg = 0; close_age = 1;
          end
        end
      end else begin
        chk("no_grant_fifo_push", 64'(enc_fifo_push), 64'(0));
        chk("no_grant_index_push", 64'(enc_index_push), 64'(0));
        chk("no_grant_req_pop", 64'(req_pop), 64'(0));
      end
      if (!enc_index_push) chk("index_data_zero", 64'(enc_index_data), 64'(0));
      pop_seen = req_pop;
      prev_gv = grant_valid;
      prev_empty = req_empty;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin stim_cnt[i] = 0; hide[i] = 0; end
    do_reset();

    // Single lane, 3-word message.
    add_msg(2, 3, 1); drive();
    wait_idle(100, "lane2_only");

    // All lanes one word each, twice; round-robin order from lane 0.
    do_reset();
    for (int l = 0; l < N; l++) add_msg(l, 1, 1);
    drive();
    wait_idle(100, "rr_round1");
    for (int l = 0; l < N; l++) add_msg(l, 1, 1);
    drive();
    wait_idle(100, "rr_round2");

    // Lane 1 goes empty mid-message while lane 0 waits.
    add_msg(1, 6, 1); drive();
    wait_mid(1, 4, "lane1_mid");
    hide[1] = 5; add_msg(0, 2, 1); drive();
    wait_idle(200, "lane1_stall");

    // Encoder FIFO full for 3 cycles mid-message.
    add_msg(3, 8, 1); drive();
    wait_mid(3, 5, "lane3_mid");
    force_full = 3; drive();
    wait_idle(200, "fifo_full");

    // Index FIFO full while the last word waits.
    force_idx = 8; add_msg(0, 3, 1); drive();
    wait_idle(200, "index_full");

    // Random traffic with random backpressure and lane gaps.
    rand_mode = 1;
    for (int c = 0; c < 600; c++) begin
      int l;
      l = $urandom_range(0, N-1);
      if ($urandom_range(0, 3) == 0 && lane_q[l].size() < 16) add_msg(l, $urandom_range(1, 6), 1);
      if ($urandom_range(0, 15) == 0) hide[$urandom_range(0, N-1)] = $urandom_range(1, 3);
      drive();
      step();
    end
    rand_mode = 0;
    wait_idle(3000, "random");

    // 300-word message: forced close at 255, remainder of 45 as the next message.
    for (int i = 0; i < 300; i++) add_word(3, $urandom, i == 299);
    drive();
    wait_idle(1000, "long_msg");

    // Reset mid-message, then lane 0 has priority again.
    add_msg(1, 10, 1); drive();
    wait_mid(1, 6, "reset_mid");
    do_reset();
    add_msg(2, 2, 1); add_msg(0, 2, 1); drive();
    wait_idle(200, "after_reset");

    for (int i = 0; i < N; i++) begin
      chk("leftover_words", 64'(exp_word[i].size()), 64'(0));
      chk("leftover_index", 64'(exp_idx[i].size()), 64'(0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
